// File: rtl/uart_pkg.sv
// Shared types and constants for the UART register bridge: FSM state
// encodings, command opcodes and default protocol bytes.
package uart_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'h55;
  localparam logic [7:0] ACK_BYTE_DEF  = 8'hAA;
  localparam logic [7:0] NAK_BYTE_DEF  = 8'hEE;

  localparam int unsigned BYTE_TIMEOUT_DEF = 50000;
  localparam int unsigned READ_TIMEOUT_DEF = 255;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_CMD,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_BUS_WRITE,
    ST_BUS_READ,
    ST_WAIT_READ,
    ST_RESPOND
  } bridge_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_WAIT_FREE,
    TX_SEND,
    TX_WAIT_DONE
  } tx_state_e;

  // Debug view of both state machines, exported on the top level.
  typedef struct packed {
    bridge_state_e bridge;
    tx_state_e     tx;
  } dbg_t;

  // True for the two opcodes the bridge understands.
  function automatic logic is_known_cmd(input logic [7:0] cmd);
    return (cmd == CMD_WRITE) || (cmd == CMD_READ);
  endfunction

endpackage

// File: rtl/uart_tx_sender.sv
// Sends one byte through the UART transmit handshake.
//
// Handshake: a one-cycle ipStart (only while opState is TX_IDLE) captures
// ipByte. The sender waits for ipTxBusy=0, then raises opTxSend with
// opTxData held stable until the UART answers with ipTxBusy=1; opTxSend then
// drops. Once ipTxBusy returns to 0 the byte is complete and opDone pulses
// for one cycle, leaving the sender idle for the next byte.
module uart_tx_sender
  import uart_pkg::*;
(
  input  logic      ipClk,
  input  logic      ipReset,
  input  logic      ipStart,
  input  logic [7:0] ipByte,
  input  logic      ipTxBusy,
  output logic [7:0] opTxData,
  output logic      opTxSend,
  output logic      opDone,
  output tx_state_e opState
);

  tx_state_e  state_q, state_d;
  logic [7:0] data_q, data_d;

  // State and byte registers; reset leaves the transmit request low.
  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      state_q <= TX_IDLE;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // Next-state logic walking one byte through the busy handshake.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    opDone  = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (ipStart) begin
          data_d  = ipByte;
          state_d = TX_WAIT_FREE;
        end
      end
      TX_WAIT_FREE: begin
        if (!ipTxBusy) state_d = TX_SEND;
      end
      TX_SEND: begin
        if (ipTxBusy) state_d = TX_WAIT_DONE;
      end
      TX_WAIT_DONE: begin
        if (!ipTxBusy) begin
          opDone  = 1'b1;
          state_d = TX_IDLE;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  assign opTxSend = (state_q == TX_SEND);
  assign opTxData = data_q;
  assign opState  = state_q;

endmodule

// File: rtl/uart_register_bridge.sv
// Command responder: decodes SYNC/CMD/ADDR[/DATA x4] packets from the UART
// receive side, runs one register-bus transaction per packet and returns
// ACK/NAK (plus read data) through uart_tx_sender.
module uart_register_bridge
  import uart_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEF,
  parameter logic [7:0]  ACK_BYTE     = ACK_BYTE_DEF,
  parameter logic [7:0]  NAK_BYTE     = NAK_BYTE_DEF,
  parameter int unsigned BYTE_TIMEOUT = BYTE_TIMEOUT_DEF,
  parameter int unsigned READ_TIMEOUT = READ_TIMEOUT_DEF
) (
  input  logic        ipClk,
  input  logic        ipReset,
  input  logic [7:0]  ipRxData,
  input  logic        ipRxValid,
  output logic [7:0]  opTxData,
  output logic        opTxSend,
  input  logic        ipTxBusy,
  output logic [7:0]  opAddress,
  output logic [31:0] opWrData,
  output logic        opWrEnable,
  output logic        opRdEnable,
  input  logic [31:0] ipRdData,
  input  logic        ipRdValid,
  output dbg_t        opDbg
);

  localparam int unsigned BT_W = $clog2(BYTE_TIMEOUT + 1);
  localparam int unsigned RD_W = $clog2(READ_TIMEOUT + 1);
  localparam logic [BT_W-1:0] BT_LAST = BT_W'(BYTE_TIMEOUT - 1);
  localparam logic [RD_W-1:0] RD_LAST = RD_W'(READ_TIMEOUT - 1);

  bridge_state_e   state_q, state_d;
  logic            rx_valid_q;
  logic [7:0]      addr_q, addr_d;
  logic [31:0]     wr_data_q, wr_data_d;
  logic            is_write_q, is_write_d;
  logic [1:0]      data_cnt_q, data_cnt_d;
  logic [BT_W-1:0] bt_cnt_q, bt_cnt_d;
  logic [RD_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [39:0]     resp_q, resp_d;
  logic [2:0]      resp_cnt_q, resp_cnt_d;
  logic            inflight_q, inflight_d;

  logic            rx_accept;
  logic            in_get;
  logic            byte_timeout;
  logic            tx_start;
  logic            tx_done;
  tx_state_e       tx_state;

  // A byte counts only on the rising edge of ipRxValid; the detector resets
  // high so a valid that is already asserted out of reset is not a byte.
  assign rx_accept    = ipRxValid & ~rx_valid_q;
  assign in_get       = (state_q == ST_GET_CMD) || (state_q == ST_GET_ADDR) ||
                        (state_q == ST_GET_DATA);
  assign byte_timeout = in_get && !rx_accept && (bt_cnt_q == BT_LAST);

  // All bridge registers; strobes derive from state so reset clears them at once.
  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      state_q    <= ST_IDLE;
      rx_valid_q <= 1'b1;
      addr_q     <= 8'h00;
      wr_data_q  <= 32'h0;
      is_write_q <= 1'b0;
      data_cnt_q <= 2'd0;
      bt_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      resp_q     <= 40'h0;
      resp_cnt_q <= 3'd0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_valid_q <= ipRxValid;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
      is_write_q <= is_write_d;
      data_cnt_q <= data_cnt_d;
      bt_cnt_q   <= bt_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      resp_q     <= resp_d;
      resp_cnt_q <= resp_cnt_d;
      inflight_q <= inflight_d;
    end
  end

  // Packet decode, bus sequencing and response-buffer shifting.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wr_data_d  = wr_data_q;
    is_write_d = is_write_q;
    data_cnt_d = data_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    resp_d     = resp_q;
    resp_cnt_d = resp_cnt_q;
    inflight_d = inflight_q;
    tx_start   = 1'b0;
    // Inter-byte gap counter: cleared by every accepted byte, idle outside packets.
    bt_cnt_d   = '0;
    if (in_get && !rx_accept) bt_cnt_d = bt_cnt_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (rx_accept && (ipRxData == SYNC_BYTE)) state_d = ST_GET_CMD;
      end
      ST_GET_CMD: begin
        if (rx_accept) begin
          if (is_known_cmd(ipRxData)) begin
            is_write_d = (ipRxData == CMD_WRITE);
            state_d    = ST_GET_ADDR;
          end else begin
            resp_d     = {NAK_BYTE, 32'h0};
            resp_cnt_d = 3'd1;
            state_d    = ST_RESPOND;
          end
        end else if (byte_timeout) begin
          state_d = ST_IDLE;
        end
      end
      ST_GET_ADDR: begin
        if (rx_accept) begin
          addr_d     = ipRxData;
          data_cnt_d = 2'd0;
          state_d    = is_write_q ? ST_GET_DATA : ST_BUS_READ;
        end else if (byte_timeout) begin
          state_d = ST_IDLE;
        end
      end
      ST_GET_DATA: begin
        if (rx_accept) begin
          wr_data_d  = {wr_data_q[23:0], ipRxData};
          data_cnt_d = data_cnt_q + 1'b1;
          if (data_cnt_q == 2'd3) state_d = ST_BUS_WRITE;
        end else if (byte_timeout) begin
          state_d = ST_IDLE;
        end
      end
      ST_BUS_WRITE: begin
        resp_d     = {ACK_BYTE, 32'h0};
        resp_cnt_d = 3'd1;
        state_d    = ST_RESPOND;
      end
      ST_BUS_READ: begin
        // A valid in the strobe cycle itself is deliberately not looked at.
        rd_cnt_d = '0;
        state_d  = ST_WAIT_READ;
      end
      ST_WAIT_READ: begin
        if (ipRdValid) begin
          resp_d     = {ACK_BYTE, ipRdData};
          resp_cnt_d = 3'd5;
          state_d    = ST_RESPOND;
        end else if (rd_cnt_q == RD_LAST) begin
          resp_d     = {NAK_BYTE, 32'h0};
          resp_cnt_d = 3'd1;
          state_d    = ST_RESPOND;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      ST_RESPOND: begin
        if (!inflight_q) begin
          tx_start   = 1'b1;
          inflight_d = 1'b1;
        end else if (tx_done) begin
          inflight_d = 1'b0;
          if (resp_cnt_q == 3'd1) begin
            state_d = ST_IDLE;
          end else begin
            resp_d     = {resp_q[31:0], 8'h00};
            resp_cnt_d = resp_cnt_q - 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  uart_tx_sender u_tx_sender (
    .ipClk    (ipClk),
    .ipReset  (ipReset),
    .ipStart  (tx_start),
    .ipByte   (resp_q[39:32]),
    .ipTxBusy (ipTxBusy),
    .opTxData (opTxData),
    .opTxSend (opTxSend),
    .opDone   (tx_done),
    .opState  (tx_state)
  );

  assign opWrEnable = (state_q == ST_BUS_WRITE);
  assign opRdEnable = (state_q == ST_BUS_READ);
  assign opAddress  = addr_q;
  assign opWrData   = wr_data_q;
  assign opDbg      = '{bridge: state_q, tx: tx_state};

endmodule

// File: tb/tb_uart_register_bridge.sv
// Bench for uart_register_bridge: directed protocol cases plus randomized
// packets, checked against expected queues built from the protocol rules.
module tb_uart_register_bridge;
  import uart_pkg::*;

  localparam int RD_TO = 255;

  logic        ipClk = 1'b0;
  logic        ipReset;
  logic [7:0]  ipRxData;
  logic        ipRxValid;
  logic [7:0]  opTxData;
  logic        opTxSend;
  logic        ipTxBusy;
  logic [7:0]  opAddress;
  logic [31:0] opWrData;
  logic        opWrEnable;
  logic        opRdEnable;
  logic [31:0] ipRdData;
  logic        ipRdValid;
  dbg_t        opDbg;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_tx_q[$];
  logic [39:0] exp_wr_q[$];
  logic [7:0]  exp_rd_q[$];
  logic [31:0] rsp_data_q[$];
  int          rsp_dly_q[$];
  logic [7:0]  pkt_q[$];

  logic        prev_wr = 1'b0;
  logic        prev_rd = 1'b0;
  logic        prev_send = 1'b0;
  logic [7:0]  prev_txd = 8'h00;

  // Clock and DUT
  always #5 ipClk = ~ipClk;

  uart_register_bridge dut (
    .ipClk      (ipClk),
    .ipReset    (ipReset),
    .ipRxData   (ipRxData),
    .ipRxValid  (ipRxValid),
    .opTxData   (opTxData),
    .opTxSend   (opTxSend),
    .ipTxBusy   (ipTxBusy),
    .opAddress  (opAddress),
    .opWrData   (opWrData),
    .opWrEnable (opWrEnable),
    .opRdEnable (opRdEnable),
    .ipRdData   (ipRdData),
    .ipRdValid  (ipRdValid),
    .opDbg      (opDbg)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Per-cycle compare of bus strobes and transmit handshake
  initial begin
    forever begin
      @(posedge ipClk);
      #1;
      if (ipReset) begin
        if (opWrEnable) begin
          check("wr_strobe_width", 64'(prev_wr), 64'd0);
          if (exp_wr_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write actual=%0h required=none", {opAddress, opWrData});
          end else begin
            check("write_addr_data", 64'({opAddress, opWrData}), 64'(exp_wr_q.pop_front()));
          end
        end
        if (opRdEnable) begin
          check("rd_strobe_width", 64'(prev_rd), 64'd0);
          if (exp_rd_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_read actual=%0h required=none", opAddress);
          end else begin
            check("read_addr", 64'(opAddress), 64'(exp_rd_q.pop_front()));
          end
        end
        if (opTxSend) begin
          check("send_while_busy", 64'(ipTxBusy), 64'd0);
          if (prev_send) check("tx_data_stable", 64'(opTxData), 64'(prev_txd));
        end
        prev_wr   = opWrEnable;
        prev_rd   = opRdEnable;
        prev_send = opTxSend;
        prev_txd  = opTxData;
      end else begin
        prev_wr   = 1'b0;
        prev_rd   = 1'b0;
        prev_send = 1'b0;
      end
    end
  end

  // UART transmitter model: takes a byte, goes busy for a few cycles
  initial begin
    logic [7:0] got;
    ipTxBusy = 1'b0;
    forever begin
      @(negedge ipClk);
      if (ipReset && opTxSend && !ipTxBusy) begin
        got = opTxData;
        if (exp_tx_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_tx_byte actual=%0h required=none", got);
        end else begin
          check("tx_byte", 64'(got), 64'(exp_tx_q.pop_front()));
        end
        repeat ($urandom_range(0, 2)) @(negedge ipClk);
        ipTxBusy = 1'b1;
        repeat ($urandom_range(2, 6)) @(negedge ipClk);
        ipTxBusy = 1'b0;
      end
    end
  end

  // Register read responder: pulses ipRdValid a chosen number of cycles after the strobe
  initial begin
    int          d;
    logic [31:0] data;
    ipRdValid = 1'b0;
    ipRdData  = 32'h0;
    forever begin
      @(negedge ipClk);
      if (ipReset && opRdEnable && rsp_dly_q.size() != 0) begin
        d    = rsp_dly_q.pop_front();
        data = rsp_data_q.pop_front();
        if (d >= 0) begin
          repeat (d) @(negedge ipClk);
          ipRdData  = data;
          ipRdValid = 1'b1;
          @(negedge ipClk);
          ipRdValid = 1'b0;
          ipRdData  = $urandom;
        end
      end
    end
  end

  // Driver tasks
  task automatic send_byte(input logic [7:0] b, input int hold);
    @(negedge ipClk);
    ipRxData  = b;
    ipRxValid = 1'b1;
    repeat (hold) @(negedge ipClk);
    ipRxValid = 1'b0;
    ipRxData  = 8'($urandom);
    repeat ($urandom_range(1, 4)) @(negedge ipClk);
  endtask

  task automatic send_pkt(input int first_hold);
    int i = 0;
    while (pkt_q.size() != 0) begin
      send_byte(pkt_q.pop_front(), (i == 0 && first_hold > 0) ? first_hold : int'($urandom_range(1, 3)));
      i++;
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_tx_q.size() != 0 || ipTxBusy || opTxSend) && n < budget) begin
      @(negedge ipClk);
      n++;
    end
    check("drain_in_time", 64'(n < budget), 64'd1);
    repeat (4) @(negedge ipClk);
    check("idle_after_txn", 64'(opDbg.bridge), 64'(ST_IDLE));
    check("bus_pending", 64'(exp_wr_q.size() + exp_rd_q.size()), 64'd0);
  endtask

  task automatic model_write(input logic [7:0] addr, input logic [31:0] data);
    exp_wr_q.push_back({addr, data});
    exp_tx_q.push_back(8'hAA);
    pkt_q = '{8'h55, 8'h01, addr, data[31:24], data[23:16], data[15:8], data[7:0]};
    send_pkt(0);
    wait_drain(400);
  endtask

  // dly: cycles from strobe to ipRdValid, -1 for never
  task automatic model_read(input logic [7:0] addr, input logic [31:0] data, input int dly,
                            input bit inject, input int sync_hold);
    exp_rd_q.push_back(addr);
    rsp_data_q.push_back(data);
    rsp_dly_q.push_back(dly);
    if (dly >= 1 && dly <= RD_TO) begin
      exp_tx_q.push_back(8'hAA);
      for (int k = 3; k >= 0; k--) exp_tx_q.push_back(8'((data >> (8 * k)) & 32'hFF));
    end else begin
      exp_tx_q.push_back(8'hEE);
    end
    pkt_q = '{8'h55, 8'h02, addr};
    send_pkt(sync_hold);
    if (inject && (dly >= 20 || dly < 1 || dly > RD_TO)) begin
      repeat (3) @(negedge ipClk);
      send_byte(8'h55, 1);
    end
    wait_drain(800);
  endtask

  // Main sequence
  initial begin
    int          kind, r, dly, n;
    logic [7:0]  b;
    ipReset   = 1'b0;
    ipRxValid = 1'b1;
    ipRxData  = 8'h55;
    repeat (3) @(negedge ipClk);
    check("rst_tx_send", 64'(opTxSend), 64'd0);
    check("rst_tx_data", 64'(opTxData), 64'd0);
    check("rst_wr_en", 64'(opWrEnable), 64'd0);
    check("rst_rd_en", 64'(opRdEnable), 64'd0);
    check("rst_addr", 64'(opAddress), 64'd0);
    check("rst_wr_data", 64'(opWrData), 64'd0);
    check("rst_state", 64'(opDbg.bridge), 64'(ST_IDLE));

    // Valid held high across reset release must not count as a SYNC
    ipReset = 1'b1;
    repeat (5) @(negedge ipClk);
    check("primed_detector", 64'(opDbg.bridge), 64'(ST_IDLE));
    ipRxValid = 1'b0;
    send_byte(8'h07, 1);
    repeat (20) @(negedge ipClk);
    check("idle_discard", 64'(opDbg.bridge), 64'(ST_IDLE));

    // Literal write: 55 01 10 DE AD BE EF
    exp_wr_q.push_back({8'h10, 32'hDEADBEEF});
    exp_tx_q.push_back(8'hAA);
    pkt_q = '{8'h55, 8'h01, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_pkt(0);
    wait_drain(400);
    check("wr_data_held", 64'(opWrData), 64'h00000000DEADBEEF);

    // Literal read: 55 02 20, valid 3 cycles after strobe
    exp_rd_q.push_back(8'h20);
    rsp_data_q.push_back(32'h12345678);
    rsp_dly_q.push_back(3);
    exp_tx_q = '{8'hAA, 8'h12, 8'h34, 8'h56, 8'h78};
    pkt_q = '{8'h55, 8'h02, 8'h20};
    send_pkt(0);
    wait_drain(400);

    // Literal read with no valid: single NAK, nothing after
    exp_rd_q.push_back(8'h30);
    rsp_data_q.push_back(32'h0);
    rsp_dly_q.push_back(-1);
    exp_tx_q.push_back(8'hEE);
    pkt_q = '{8'h55, 8'h02, 8'h30};
    send_pkt(0);
    wait_drain(800);
    repeat (300) @(negedge ipClk);

    // Read timeout boundaries: strobe-cycle valid, last legal cycle, one too late
    model_read(8'h31, 32'hA5A5_0001, 0, 1'b0, 0);
    model_read(8'h32, 32'hA5A5_0002, RD_TO, 1'b0, 0);
    model_read(8'h33, 32'hA5A5_0003, RD_TO + 1, 1'b0, 0);

    // Bad command then garbage before a good write
    exp_tx_q.push_back(8'hEE);
    pkt_q = '{8'h55, 8'h07};
    send_pkt(0);
    wait_drain(400);
    send_byte(8'h00, 1);
    send_byte(8'hFF, 2);
    model_write(8'h11, 32'h0BAD_F00D);

    // Partial packet then a long silence returns to IDLE without a strobe
    pkt_q = '{8'h55, 8'h01, 8'h10, 8'hDE};
    send_pkt(0);
    repeat (50010) @(negedge ipClk);
    check("byte_timeout_idle", 64'(opDbg.bridge), 64'(ST_IDLE));
    model_write(8'h12, 32'h01020304);

    // SYNC with valid held high for 10 cycles counts once
    model_read(8'h40, 32'h89ABCDEF, 5, 1'b0, 10);

    // Randomized packets
    for (int t = 0; t < 25; t++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 3) begin
        model_write(8'($urandom), $urandom);
      end else if (kind <= 7) begin
        r = $urandom_range(0, 9);
        case (r)
          0:       dly = -1;
          1:       dly = RD_TO;
          2:       dly = RD_TO + 1;
          3:       dly = 0;
          default: dly = $urandom_range(1, 60);
        endcase
        model_read(8'($urandom), $urandom, dly, 1'($urandom_range(0, 1)), 0);
      end else if (kind == 8) begin
        b = 8'($urandom);
        if (b == CMD_WRITE || b == CMD_READ) b = 8'h00;
        exp_tx_q.push_back(8'hEE);
        pkt_q = '{8'h55, b};
        send_pkt(0);
        wait_drain(400);
      end else begin
        n = $urandom_range(1, 3);
        for (int k = 0; k < n; k++) begin
          b = 8'($urandom);
          if (b == 8'h55) b = 8'h5A;
          send_byte(b, $urandom_range(1, 3));
        end
      end
    end

    // Reset while the response is being sent
    exp_rd_q.push_back(8'h44);
    rsp_data_q.push_back(32'hCAFEF00D);
    rsp_dly_q.push_back(40);
    exp_tx_q = '{8'hAA, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
    pkt_q = '{8'h55, 8'h02, 8'h44};
    send_pkt(0);
    n = 0;
    while (n < 500) begin
      @(posedge ipClk);
      #2;
      if (opTxSend) break;
      n++;
    end
    check("respond_reached", 64'(opTxSend), 64'd1);
    ipReset = 1'b0;
    #1;
    check("rst_mid_tx_send", 64'(opTxSend), 64'd0);
    check("rst_mid_wr_en", 64'(opWrEnable), 64'd0);
    check("rst_mid_rd_en", 64'(opRdEnable), 64'd0);
    check("rst_mid_state", 64'(opDbg.bridge), 64'(ST_IDLE));
    exp_tx_q.delete();
    repeat (3) @(negedge ipClk);
    ipReset = 1'b1;
    repeat (40) @(negedge ipClk);
    check("post_reset_idle", 64'(opDbg.bridge), 64'(ST_IDLE));
    model_write(8'h7F, 32'h5555AAAA);

    check("exp_tx_empty", 64'(exp_tx_q.size()), 64'd0);
    check("exp_rd_resp_empty", 64'(rsp_dly_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
